// File: rtl/decision_tally_pkg.sv
// rtl/decision_tally_pkg.sv - decision class codes and tally FSM state encoding
package decision_tally_pkg;

  localparam logic [7:0] Y1 = 8'd1;
  localparam logic [7:0] Y2 = 8'd2;
  localparam logic [7:0] Y3 = 8'd3;
  localparam logic [7:0] Y4 = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  function automatic logic is_valid_code(input logic [7:0] code);
    return (code >= Y1) && (code <= Y4);
  endfunction

endpackage

// File: rtl/tally_argmax.sv
// rtl/tally_argmax.sv - argmax over four class counters, ties resolve to the lowest code
module tally_argmax
  import decision_tally_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0] cnt_y1,
  input  logic [CNT_W-1:0] cnt_y2,
  input  logic [CNT_W-1:0] cnt_y3,
  input  logic [CNT_W-1:0] cnt_y4,
  output logic [2:0]       code
);

  logic [CNT_W-1:0] best;

  // Strict greater-than keeps the earlier (lower) code on a tie.
  always_comb begin
    code = 3'(Y1);
    best = cnt_y1;
    if (cnt_y2 > best) begin
      code = 3'(Y2);
      best = cnt_y2;
    end
    if (cnt_y3 > best) begin
      code = 3'(Y3);
      best = cnt_y3;
    end
    if (cnt_y4 > best) begin
      code = 3'(Y4);
      best = cnt_y4;
    end
  end

endmodule

// File: rtl/decision_tally.sv
// rtl/decision_tally.sv - windowed majority vote of decision codes; DECISION_TALLY_ERRCNT_EN enables the invalid-code counter
module decision_tally
  import decision_tally_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       y_i,
  input  logic             y_valid_i,
  input  logic             clear_i,
  input  logic [1:0]       hist_sel_i,
  output logic [CNT_W-1:0] hist_o,
  output logic [7:0]       result_o,
  output logic             result_valid_o,
  output logic [7:0]       err_cnt_o
);

  state_t                 state, state_nxt;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [7:0]             win_q, win_nxt, win_base;
  logic                   accept, report_now;
  logic [1:0]             idx;
  logic [2:0]             argmax_code;

  // REPORT lasts one cycle: its counters are only shown, so the next window starts from zero.
  always_comb begin
    accept     = y_valid_i && is_valid_code(y_i) && !clear_i;
    idx        = y_i[1:0] - 2'd1;
    cnt_nxt    = (state == ST_REPORT) ? '0 : cnt_q;
    win_base   = (state == ST_REPORT) ? 8'd0 : win_q;
    win_nxt    = win_base;
    state_nxt  = state;
    report_now = 1'b0;
    if (clear_i) begin
      cnt_nxt   = '0;
      win_nxt   = 8'd0;
      state_nxt = ST_IDLE;
    end else if (accept) begin
      cnt_nxt[idx] = cnt_nxt[idx] + CNT_W'(1);
      win_nxt      = win_base + 8'd1;
      if (win_nxt == 8'(WINDOW)) begin
        state_nxt  = ST_REPORT;
        report_now = 1'b1;
      end else begin
        state_nxt  = ST_ACCUM;
      end
    end else if (state == ST_REPORT) begin
      state_nxt = ST_IDLE;
    end
  end

  // Argmax sees the updated counts so the final sample of the window is included.
  tally_argmax #(.CNT_W(CNT_W)) u_argmax (
    .cnt_y1 (cnt_nxt[0]),
    .cnt_y2 (cnt_nxt[1]),
    .cnt_y3 (cnt_nxt[2]),
    .cnt_y4 (cnt_nxt[3]),
    .code   (argmax_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt_q          <= '0;
      win_q          <= 8'd0;
      result_o       <= 8'd0;
      result_valid_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt_q          <= cnt_nxt;
      win_q          <= win_nxt;
      result_valid_o <= report_now;
      if (report_now) begin
        result_o <= {5'd0, argmax_code};
      end
    end
  end

  assign hist_o = cnt_q[hist_sel_i];

`ifdef DECISION_TALLY_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 8'd0;
    end else if (y_valid_i && !is_valid_code(y_i) && !clear_i && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt_o = err_q;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_decision_tally.sv
// tb/tb_decision_tally.sv - randomized and directed bench for decision_tally against a window-queue model
module tb_decision_tally;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       y_i;
  logic             y_valid_i;
  logic             clear_i;
  logic [1:0]       hist_sel_i;
  logic [CNT_W-1:0] hist_o;
  logic [7:0]       result_o;
  logic             result_valid_o;
  logic [7:0]       err_cnt_o;

  decision_tally #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .y_i            (y_i),
    .y_valid_i      (y_valid_i),
    .clear_i        (clear_i),
    .hist_sel_i     (hist_sel_i),
    .hist_o         (hist_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .err_cnt_o      (err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int win_samples[$];
  int rep_counts[4];
  bit in_report;
  int exp_result;
  bit exp_pulse;
  int exp_err;
  int pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_hist(input int sel);
    int n;
    if (in_report) return rep_counts[sel];
    n = 0;
    foreach (win_samples[i]) if (win_samples[i] == sel + 1) n++;
    return n;
  endfunction

  task automatic model_reset();
    win_samples.delete();
    in_report  = 1'b0;
    exp_result = 0;
    exp_pulse  = 1'b0;
    exp_err    = 0;
    foreach (rep_counts[i]) rep_counts[i] = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] y, input logic clr);
    int best;
    bit valid_code;
    valid_code = (y >= 8'd1) && (y <= 8'd4);
    exp_pulse  = 1'b0;
    in_report  = 1'b0;
    if (clr) begin
      win_samples.delete();
    end else if (v && valid_code) begin
      win_samples.push_back(int'(y));
      if (win_samples.size() == WINDOW) begin
        foreach (rep_counts[i]) rep_counts[i] = 0;
        foreach (win_samples[i]) rep_counts[win_samples[i] - 1]++;
        best = 1;
        for (int c = 2; c <= 4; c++) if (rep_counts[c-1] > rep_counts[best-1]) best = c;
        exp_result = best;
        exp_pulse  = 1'b1;
        in_report  = 1'b1;
        win_samples.delete();
      end
    end
`ifdef DECISION_TALLY_ERRCNT_EN
    if (!clr && v && !valid_code && exp_err < 255) exp_err++;
`endif
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".hist"},   32'(hist_o), 32'(model_hist(int'(hist_sel_i))));
    check({tag, ".result"}, 32'(result_o), 32'(exp_result));
    check({tag, ".pulse"},  32'(result_valid_o), 32'(exp_pulse));
    check({tag, ".err"},    32'(err_cnt_o), 32'(exp_err));
    if (result_valid_o) pulses++;
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] y,
                      input logic clr, input logic [1:0] sel);
    y_valid_i  = v;
    y_i        = y;
    clear_i    = clr;
    hist_sel_i = sel;
    @(posedge clk);
    model_edge(v, y, clr);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, 8'd0, 1'b0, 2'd0);
  endtask

  task automatic do_reset(input string tag);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_hist"},   32'(hist_o), 32'd0);
    check({tag, ".rst_result"}, 32'(result_o), 32'd0);
    check({tag, ".rst_pulse"},  32'(result_valid_o), 32'd0);
    check({tag, ".rst_err"},    32'(err_cnt_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int seq[8];
    int p0;
    logic v, clr;
    logic [7:0] y;

    reset = 1'b0; y_i = 8'd0; y_valid_i = 1'b0; clear_i = 1'b0; hist_sel_i = 2'd0;
    pulses = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // eight 3s: one report, hist(sel=2)=8 during REPORT
    p0 = pulses;
    for (int i = 0; i < 8; i++) step("all3", 1'b1, 8'd3, 1'b0, 2'd2);
    check("all3.pulses", 32'(pulses - p0), 32'd1);
    check("all3.hist8", 32'(hist_o), 32'd8);
    idle_step("all3.after");

    // tie between 2 and 4 resolves low
    seq = '{1, 1, 2, 2, 2, 4, 4, 4};
    for (int i = 0; i < 8; i++) step("tie", 1'b1, 8'(seq[i]), 1'b0, 2'd1);
    check("tie.result", 32'(result_o), 32'd2);
    idle_step("tie.after");

    // invalid codes interleaved
    for (int i = 0; i < 8; i++) begin
      step("inv.v", 1'b1, 8'd4, 1'b0, 2'd3);
      if (i == 2) step("inv.x7", 1'b1, 8'h07, 1'b0, 2'd3);
      if (i == 5) step("inv.x0", 1'b1, 8'h00, 1'b0, 2'd3);
    end
    check("inv.result", 32'(result_o), 32'd4);
    idle_step("inv.after");

    // five 2s, clear with a valid code, eight 1s
    p0 = pulses;
    for (int i = 0; i < 5; i++) step("clr.pre", 1'b1, 8'd2, 1'b0, 2'd1);
    step("clr.hit", 1'b1, 8'd2, 1'b1, 2'd1);
    for (int i = 0; i < 8; i++) step("clr.post", 1'b1, 8'd1, 1'b0, 2'd0);
    check("clr.pulses", 32'(pulses - p0), 32'd1);
    check("clr.result", 32'(result_o), 32'd1);
    idle_step("clr.after");

    // reset mid-window, then a full window
    for (int i = 0; i < 4; i++) step("rst.pre", 1'b1, 8'd3, 1'b0, 2'd2);
    do_reset("rst.mid");
    for (int i = 0; i < 8; i++) step("rst.post", 1'b1, 8'd4, 1'b0, 2'd3);
    idle_step("rst.after");

    // continuous 2s for 16 cycles
    p0 = pulses;
    for (int i = 0; i < 16; i++) step("cont", 1'b1, 8'd2, 1'b0, 2'd1);
    check("cont.pulses", 32'(pulses - p0), 32'd2);
    idle_step("cont.after");

    // randomized traffic with occasional clear and reset
    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 99) < 75);
      clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 85) y = 8'($urandom_range(1, 4));
      else                            y = 8'($urandom_range(0, 255));
      step("rand", v, y, clr, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 499) == 0) do_reset("rand.rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
